otn_frame_checker: RTL and testbench
====================================

# otn_frame_checker

Receive-side frame checker for the OTN/ARQ link. It sits directly downstream of the line UART receiver that deserializes the sender's `o_otn_rx_data` stream, and consumes that byte stream. It performs these steps:
- Hunts for the frame alignment signal (FAS).
- Buffers one frame's payload and checks its CRC-8.
- Releases good payloads to the client UART TX FIFO.
- Drives the acknowledge line back into the sender's `i_otn_tx_ack`.

## Interface
Parameters:
- `PYLD_LEN`, default 16: payload bytes per frame, range 1–255.
- `ACK_CYCLES`, default 1760: clock cycles the acknowledge pulse is held high. This is 2 line bit times at 16x baud with a 55-clock enable period.

Ports:
- `i_clk`, input, 1: system clock, 100 MHz.
- `i_rst_n`, input, 1: asynchronous active-low reset.
- `i_line_data`, input, 8: byte from the line UART receiver.
- `i_line_data_valid`, input, 1: one-cycle strobe per received byte. There is no backpressure.
- `i_arq_en`, input, 1: enables CRC check and ACK. Sampled when the first FAS byte is matched.
- `o_pyld_data`, output, 8: released payload byte.
- `o_pyld_data_valid`, output, 1: AXI-Stream valid.
- `i_pyld_data_ready`, input, 1: AXI-Stream ready.
- `o_otn_tx_ack`, output, 1: acknowledge to the sender. Active high.
- `o_crc_val`, output, 8: CRC computed over the last completed frame.
- `o_good_cnt`, output, 8: count of good frames. Wraps.
- `o_bad_cnt`, output, 8: count of bad frames (CRC mismatch). Wraps.
- `o_busy`, output, 1: high in `RELEASE` and `ACK`. Line bytes are dropped while it is high.

## Operation
- Frame format: FAS `0xF6` `0xF6` `0x28`, then `PYLD_LEN` payload bytes, then one CRC byte.
- CRC rules:
  - Polynomial x^8+x^2+x+1 (`0x07`), initial value `0x00`, MSB-first, no reflection, no final XOR.
  - Computed over the payload bytes only.
  - Computed byte-serially, one byte per valid strobe.
- States: `HUNT`, `F1`, `F2`, `PYLD`, `CRC`, `RELEASE`, `ACK`.
- Transitions, all on `i_line_data_valid`:
  - `HUNT`: `0xF6` goes to `F1`. Any other byte stays in `HUNT`.
  - `F1`: `0xF6` goes to `F2`. Any other byte goes to `HUNT`.
  - `F2`: `0x28` goes to `PYLD` and clears the byte counter and CRC. `0xF6` stays in `F2` (overlap). Any other byte goes to `HUNT`.
  - `PYLD`: the byte is written to buffer[count], the CRC is updated and count is incremented. After byte `PYLD_LEN-1` the state goes to `CRC`.
  - `CRC`: the received byte is compared with the computed CRC and `o_crc_val` is updated.
    - If they match, or if ARQ is disabled: `o_good_cnt` increments and the state goes to `RELEASE`.
    - Otherwise: `o_bad_cnt` increments, the buffer is discarded and the state goes to `HUNT`.
  - `RELEASE`: presents buffer[0..PYLD_LEN-1] in order on the AXI-Stream port. After the last handshake:
    - With ARQ enabled, the state goes to `ACK`.
    - With ARQ disabled, the state goes to `HUNT`.
  - `ACK`: `o_otn_tx_ack` is held high for `ACK_CYCLES` cycles, then the state goes to `HUNT`.
- Latched ARQ: `i_arq_en` is latched on the `HUNT`→`F1` transition. A change mid-frame has no effect on the current frame.
- Dropped bytes: line bytes arriving in `RELEASE` or `ACK` are dropped and do not affect the FAS search.
- Buffer: a `PYLD_LEN`×8 register array. The byte counter is `$clog2(PYLD_LEN+1)` bits wide. The ACK counter is `$clog2(ACK_CYCLES+1)` bits wide.
- Counters: `o_good_cnt` and `o_bad_cnt` wrap from 255 to 0.

## Timing
- Reset values: all outputs are 0, the state is `HUNT` and the buffer contents are don't-care. Reset takes effect immediately (asynchronous), including mid-frame, mid-release and mid-ACK. `o_otn_tx_ack` drops to 0 with no glitch extension.
- Registered outputs: `o_crc_val`, the counters and the `RELEASE` entry are all registered on the cycle the CRC byte's valid strobe is sampled.
- Release latency: `o_pyld_data_valid` rises on the first cycle after that edge, i.e. 1 cycle after the CRC strobe.
- Release handshake:
  - Valid and data hold stable until ready is seen.
  - One byte transfers per cycle while ready is high.
  - Valid deasserts the cycle after the final handshake.
- ACK timing: `o_otn_tx_ack` rises the cycle after the final payload handshake and is high for exactly `ACK_CYCLES` cycles. `o_busy` falls the same cycle the ACK falls.
- Throughput: `PYLD`/`CRC` accept a byte on any cycle with valid high, so back-to-back strobes are legal.

## Test plan
- Good frame, ARQ on, ready held high:
  - Stimulus: F6 F6 28, payload 0x00..0x0F, CRC byte = the computed value.
  - Required response: 16 payload bytes out in consecutive cycles, 0x00..0x0F; `o_good_cnt`=1; ack high for exactly 1760 cycles.
- Corrupted CRC:
  - Stimulus: the same frame with the CRC byte XOR 0x01.
  - Required response: no `o_pyld_data_valid`; `o_bad_cnt`=1; `o_otn_tx_ack` stays 0; a following good frame is accepted.
- FAS overlap and false start:
  - Stimulus: F6 F6 F6 28 + frame, and separately F6 28 + frame bytes.
  - Required response: the first stream is detected; the second produces no output and no counter change.
- Backpressure:
  - Stimulus: ready toggles 1/0 each cycle during `RELEASE`.
  - Required response: all 16 bytes are delivered in order with no duplicates; the ack starts only after the 16th handshake.
- ARQ off:
  - Stimulus: `i_arq_en`=0 with a wrong CRC.
  - Required response: payload is released; `o_good_cnt` increments; no ack pulse.
- Reset mid-`ACK`:
  - Stimulus: assert `i_rst_n`=0 for 1 cycle during `ACK`.
  - Required response: ack=0 immediately; all counters are 0; the next good frame is processed normally.

Source files
------------

// File: rtl/otn_frame_checker.sv
// OTN/ARQ receive checker: FAS hunt, payload buffer + CRC-8 check, AXI-Stream release, ACK pulse.
// Release valid rises 1 cycle after the CRC strobe; the line has no backpressure, so bytes arriving while busy are dropped.
module otn_frame_checker #(
    parameter int PYLD_LEN   = 16,
    parameter int ACK_CYCLES = 1760
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_line_data,
    input  logic       i_line_data_valid,
    input  logic       i_arq_en,
    output logic [7:0] o_pyld_data,
    output logic       o_pyld_data_valid,
    input  logic       i_pyld_data_ready,
    output logic       o_otn_tx_ack,
    output logic [7:0] o_crc_val,
    output logic [7:0] o_good_cnt,
    output logic [7:0] o_bad_cnt,
    output logic       o_busy
);
    localparam int CW = $clog2(PYLD_LEN + 1);
    localparam int AW = $clog2(ACK_CYCLES + 1);
    localparam int IW = (PYLD_LEN > 1) ? $clog2(PYLD_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(PYLD_LEN - 1);
    localparam logic [AW-1:0] LAST_ACK = AW'(ACK_CYCLES - 1);

    localparam logic [2:0] S_HUNT = 3'd0;
    localparam logic [2:0] S_F1   = 3'd1;
    localparam logic [2:0] S_F2   = 3'd2;
    localparam logic [2:0] S_PYLD = 3'd3;
    localparam logic [2:0] S_CRC  = 3'd4;
    localparam logic [2:0] S_REL  = 3'd5;
    localparam logic [2:0] S_ACK  = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rd_idx;
    logic [CW-1:0] rd_nxt;
    logic [AW-1:0] ack_cnt;
    logic [7:0]    crc;
    logic [7:0]    crc_nxt;
    logic          arq_lat;
    logic [7:0]    pyld_buf [PYLD_LEN];

    // MSB-first CRC-8, poly 0x07, one whole byte per call
    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    assign crc_nxt = crc8_byte(crc, i_line_data);
    assign rd_nxt  = rd_idx + 1'b1;
    assign o_busy  = (state == S_REL) || (state == S_ACK);

    always_ff @(posedge i_clk) begin
        if (state == S_PYLD && i_line_data_valid) begin
            pyld_buf[cnt[IW-1:0]] <= i_line_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= S_HUNT;
            cnt               <= '0;
            rd_idx            <= '0;
            ack_cnt           <= '0;
            crc               <= '0;
            arq_lat           <= 1'b0;
            o_pyld_data       <= '0;
            o_pyld_data_valid <= 1'b0;
            o_otn_tx_ack      <= 1'b0;
            o_crc_val         <= '0;
            o_good_cnt        <= '0;
            o_bad_cnt         <= '0;
        end else begin
            case (state)
                S_HUNT: if (i_line_data_valid && i_line_data == 8'hF6) begin
                    state   <= S_F1;
                    arq_lat <= i_arq_en;
                end
                S_F1: if (i_line_data_valid) begin
                    state <= (i_line_data == 8'hF6) ? S_F2 : S_HUNT;
                end
                S_F2: if (i_line_data_valid) begin
                    if (i_line_data == 8'h28) begin
                        state <= S_PYLD;
                        cnt   <= '0;
                        crc   <= '0;
                    end else if (i_line_data != 8'hF6) begin
                        state <= S_HUNT;
                    end
                end
                S_PYLD: if (i_line_data_valid) begin
                    crc <= crc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state <= S_CRC;
                    end
                end
                S_CRC: if (i_line_data_valid) begin
                    o_crc_val <= crc;
                    if (i_line_data == crc || !arq_lat) begin
                        o_good_cnt        <= o_good_cnt + 1'b1;
                        state             <= S_REL;
                        rd_idx            <= '0;
                        o_pyld_data       <= pyld_buf[0];
                        o_pyld_data_valid <= 1'b1;
                    end else begin
                        o_bad_cnt <= o_bad_cnt + 1'b1;
                        state     <= S_HUNT;
                    end
                end
                S_REL: if (i_pyld_data_ready) begin
                    if (rd_idx == LAST_IDX) begin
                        o_pyld_data_valid <= 1'b0;
                        state             <= arq_lat ? S_ACK : S_HUNT;
                        o_otn_tx_ack      <= arq_lat;
                        ack_cnt           <= '0;
                    end else begin
                        rd_idx      <= rd_nxt;
                        o_pyld_data <= pyld_buf[rd_nxt[IW-1:0]];
                    end
                end
                S_ACK: begin
                    // ack was raised on entry, so it drops on the ACK_CYCLES-th edge
                    if (ack_cnt == LAST_ACK) begin
                        o_otn_tx_ack <= 1'b0;
                        state        <= S_HUNT;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                default: state <= S_HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_otn_frame_checker.sv
// Directed bench for otn_frame_checker: good/bad CRC, FAS overlap, false start, backpressure, ARQ off, reset mid-ACK.
module tb_otn_frame_checker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ldat;
    logic       lvld;
    logic       arq;
    logic       rdy;
    logic [7:0] pdat;
    logic       pvld;
    logic       ack;
    logic [7:0] crc_val;
    logic [7:0] good_cnt;
    logic [7:0] bad_cnt;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    otn_frame_checker dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_line_data       (ldat),
        .i_line_data_valid (lvld),
        .i_arq_en          (arq),
        .o_pyld_data       (pdat),
        .o_pyld_data_valid (pvld),
        .i_pyld_data_ready (rdy),
        .o_otn_tx_ack      (ack),
        .o_crc_val         (crc_val),
        .o_good_cnt        (good_cnt),
        .o_bad_cnt         (bad_cnt),
        .o_busy            (busy)
    );

    always #5 clk = ~clk;

    // ---------------- monitor (negedge sampling) ----------------
    int         cyc = 0;
    logic [7:0] cap_q [$];
    int         cap_cyc [$];
    int         last_hs_cyc = 0;
    int         ack_rise_cyc = 0;
    int         ack_hi = 0;
    int         stab_err = 0;
    int         busy_err = 0;
    logic       prev_vld = 1'b0;
    logic       prev_rdy = 1'b0;
    logic       prev_ack = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pvld && rdy) begin
            cap_q.push_back(pdat);
            cap_cyc.push_back(cyc);
            last_hs_cyc = cyc;
        end
        if (prev_vld && !prev_rdy && rst_n && (!pvld || pdat !== prev_dat)) stab_err++;
        if (ack) ack_hi++;
        if (ack && !prev_ack) ack_rise_cyc = cyc;
        if (ack && !busy) busy_err++;
        if (prev_ack && !ack && busy) busy_err++;
        prev_vld = pvld;
        prev_rdy = rdy;
        prev_ack = ack;
        prev_dat = pdat;
    end

    // ---------------- helpers ----------------
    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // bit-serial reference CRC over payload base, base+1, ... base+15
    function automatic logic [7:0] crc_of(input logic [7:0] base);
        logic [7:0] c;
        logic [7:0] d;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 16; i++) begin
            d = base + 8'(i);
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ d[b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic put(input logic [7:0] b);
        @(posedge clk);
        #1;
        ldat = b;
        lvld = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        lvld = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [7:0] crc_xor, input bit flip_arq);
        put(8'hF6);
        put(8'hF6);
        put(8'h28);
        if (flip_arq) arq = ~arq;
        for (int i = 0; i < 16; i++) put(base + 8'(i));
        put(crc_of(base) ^ crc_xor);
        idle();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 5000);
        chk_eq(tag, busy, 1'b0);
    endtask

    task automatic check_frame(input string tag, input int base_idx, input logic [7:0] base);
        chk_eq({tag, "_count"}, cap_q.size() - base_idx, 16);
        for (int i = 0; i < 16; i++) begin
            if (base_idx + i < cap_q.size()) chk_eq(tag, cap_q[base_idx + i], base + 8'(i));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int q0;
        int a0;
        int n;
        rst_n = 1'b0;
        ldat  = 8'h00;
        lvld  = 1'b0;
        arq   = 1'b1;
        rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_eq("rst_vld",  pvld, 1'b0);
        chk_eq("rst_dat",  pdat, 8'h00);
        chk_eq("rst_ack",  ack, 1'b0);
        chk_eq("rst_crc",  crc_val, 8'h00);
        chk_eq("rst_good", good_cnt, 8'h00);
        chk_eq("rst_bad",  bad_cnt, 8'h00);
        chk_eq("rst_busy", busy, 1'b0);

        // good frame, ARQ on, ready high
        q0 = cap_q.size();
        a0 = ack_hi;
        send_frame(8'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk_eq("t1_latency", pvld, 1'b1);
        chk_eq("t1_crc", crc_val, crc_of(8'h00));
        chk_eq("t1_good", good_cnt, 8'd1);
        wait_idle("t1_idle");
        check_frame("t1_data", q0, 8'h00);
        if (cap_cyc.size() >= q0 + 16) chk_eq("t1_consecutive", cap_cyc[q0 + 15] - cap_cyc[q0], 15);
        chk_eq("t1_ack_len", ack_hi - a0, 1760);
        chk_eq("t1_ack_start", ack_rise_cyc - last_hs_cyc, 1);
        chk_eq("t1_bad", bad_cnt, 8'd0);

        // corrupted CRC, then a good frame
        q0 = cap_q.size();
        a0 = ack_hi;
        send_frame(8'h00, 8'h01, 1'b0);
        @(negedge clk);
        chk_eq("t2_bad", bad_cnt, 8'd1);
        chk_eq("t2_good", good_cnt, 8'd1);
        chk_eq("t2_crc", crc_val, crc_of(8'h00));
        repeat (20) @(negedge clk);
        chk_eq("t2_no_out", cap_q.size() - q0, 0);
        chk_eq("t2_no_ack", ack_hi - a0, 0);
        q0 = cap_q.size();
        send_frame(8'h40, 8'h00, 1'b0);
        wait_idle("t2b_idle");
        chk_eq("t2b_good", good_cnt, 8'd2);
        check_frame("t2b_data", q0, 8'h40);

        // FAS overlap: F6 F6 F6 28
        q0 = cap_q.size();
        put(8'hF6);
        send_frame(8'hA0, 8'h00, 1'b0);
        wait_idle("t3_idle");
        chk_eq("t3_good", good_cnt, 8'd3);
        check_frame("t3_data", q0, 8'hA0);

        // false start: F6 28 + frame bytes
        q0 = cap_q.size();
        a0 = ack_hi;
        put(8'hF6);
        put(8'h28);
        for (int i = 0; i < 16; i++) put(8'h10 + 8'(i));
        put(crc_of(8'h10));
        idle();
        repeat (20) @(negedge clk);
        chk_eq("t3f_good", good_cnt, 8'd3);
        chk_eq("t3f_bad", bad_cnt, 8'd1);
        chk_eq("t3f_no_out", cap_q.size() - q0, 0);
        chk_eq("t3f_no_ack", ack_hi - a0, 0);

        // backpressure: ready toggles each cycle
        q0 = cap_q.size();
        a0 = ack_hi;
        rdy = 1'b0;
        send_frame(8'h30, 8'h00, 1'b0);
        n = 0;
        while (cap_q.size() - q0 < 16 && n < 200) begin
            @(posedge clk);
            #1 rdy = ~rdy;
            n++;
        end
        rdy = 1'b1;
        wait_idle("t4_idle");
        check_frame("t4_data", q0, 8'h30);
        chk_eq("t4_ack_start", ack_rise_cyc - last_hs_cyc, 1);
        chk_eq("t4_ack_len", ack_hi - a0, 1760);
        chk_eq("t4_good", good_cnt, 8'd4);

        // ARQ off with wrong CRC; ARQ flipped on mid-frame must not matter
        q0 = cap_q.size();
        a0 = ack_hi;
        arq = 1'b0;
        send_frame(8'h50, 8'h55, 1'b1);
        wait_idle("t5_idle");
        check_frame("t5_data", q0, 8'h50);
        chk_eq("t5_good", good_cnt, 8'd5);
        chk_eq("t5_bad", bad_cnt, 8'd1);
        chk_eq("t5_no_ack", ack_hi - a0, 0);
        chk_eq("t5_crc", crc_val, crc_of(8'h50));

        // reset during ACK
        arq = 1'b1;
        send_frame(8'h60, 8'h00, 1'b0);
        n = 0;
        while (!ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_eq("t6_ack_seen", ack, 1'b1);
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_eq("t6_ack_drop", ack, 1'b0);
        chk_eq("t6_good0", good_cnt, 8'd0);
        chk_eq("t6_bad0", bad_cnt, 8'd0);
        chk_eq("t6_crc0", crc_val, 8'd0);
        chk_eq("t6_busy0", busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        q0 = cap_q.size();
        a0 = ack_hi;
        send_frame(8'h70, 8'h00, 1'b0);
        wait_idle("t6_idle");
        check_frame("t6_data", q0, 8'h70);
        chk_eq("t6_good", good_cnt, 8'd1);
        chk_eq("t6_ack_len", ack_hi - a0, 1760);

        chk_eq("hold_stable", stab_err, 0);
        chk_eq("busy_vs_ack", busy_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
